// File: rtl/eth_pkg.sv
// Ethernet/IP/UDP definitions shared by the UDP transmit and receive paths:
// header length, the UDP framer state encoding and small header helpers.
package eth_pkg;

    localparam logic [15:0] LEN_UDP_HEADER = 16'd8;

    typedef enum logic [2:0] {
        IDLE,
        PORT_SOURCE,
        PORT_DESTINATION,
        LENGTH,
        CHECKSUM,
        PAYLOAD
    } udp_tx_state_t;

    // Header words go out big-endian: high byte at count 0, low byte at count 1.
    function automatic logic [7:0] header_byte(input logic [15:0] word, input logic low);
        return low ? word[7:0] : word[15:8];
    endfunction

    // Header state that follows once both bytes of the current header word are sent.
    function automatic udp_tx_state_t header_next(input udp_tx_state_t s);
        case (s)
            PORT_SOURCE:      return PORT_DESTINATION;
            PORT_DESTINATION: return LENGTH;
            LENGTH:           return CHECKSUM;
            CHECKSUM:         return PAYLOAD;
            default:          return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/udp_header_tx_if.sv
// Datagram request, payload stream and framed output stream of the UDP transmit framer.
// Optional macro UDP_CHECKSUM_EN adds the checksum request field.
interface udp_header_tx_if;

    logic        start;
    logic [15:0] port_s;
    logic [15:0] port_d;
    logic [15:0] payload_len;
`ifdef UDP_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        len_err;

    modport master (
        input  start, port_s, port_d, payload_len,
`ifdef UDP_CHECKSUM_EN
        input  checksum,
`endif
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last, busy, len_err
    );

    modport slave (
        output start, port_s, port_d, payload_len,
`ifdef UDP_CHECKSUM_EN
        output checksum,
`endif
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last, busy, len_err
    );

endinterface

// File: rtl/udp_header_tx.sv
// Transmit-side UDP framer: serialises the 8-byte UDP header MSB first, then passes payload through.
// Optional macro UDP_CHECKSUM_EN sends a caller-supplied checksum instead of 16'h0000.
module udp_header_tx
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic            aclk,
    input  logic            areset,
    udp_header_tx_if.master bus
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    udp_tx_state_t state, state_next;
    logic [15:0]   count, count_next;
    logic          load;

    logic [15:0]   src_q;
    logic [15:0]   dst_q;
    logic [15:0]   len_buf;
    logic [15:0]   plen_q;
`ifdef UDP_CHECKSUM_EN
    logic [15:0]   csum_q;
`endif
    logic [15:0]   word;
    logic          word_done;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            count <= 16'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Request fields are plain data: captured on an accepted start, never reset.
    always_ff @(posedge aclk) begin
        if (load) begin
            src_q   <= bus.port_s;
            dst_q   <= bus.port_d;
            plen_q  <= bus.payload_len;
            len_buf <= bus.payload_len + LEN_UDP_HEADER;
`ifdef UDP_CHECKSUM_EN
            csum_q  <= bus.checksum;
`endif
        end
    end

    always_comb begin
        word = 16'h0000;
        case (state)
            PORT_SOURCE:      word = src_q;
            PORT_DESTINATION: word = dst_q;
            LENGTH:           word = len_buf;
`ifdef UDP_CHECKSUM_EN
            CHECKSUM:         word = csum_q;
`else
            CHECKSUM:         word = 16'h0000;
`endif
            default:          word = 16'h0000;
        endcase
    end

    assign word_done = (count == 16'd1) && bus.m_ready;

    always_comb begin
        state_next  = state;
        count_next  = count;
        load        = 1'b0;
        bus.m_data  = 8'h00;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.s_ready = 1'b0;
        bus.len_err = 1'b0;
        bus.busy    = (state != IDLE);

        case (state)
            IDLE: begin
                count_next = 16'd0;
                if (bus.start) begin
                    if (bus.payload_len > MAX_LEN) begin
                        bus.len_err = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = PORT_SOURCE;
                    end
                end
            end

            PORT_SOURCE, PORT_DESTINATION, LENGTH, CHECKSUM: begin
                bus.m_valid = 1'b1;
                bus.m_data  = header_byte(word, count[0]);
                // An empty datagram ends on the checksum low byte.
                if (state == CHECKSUM && plen_q == 16'd0 && count == 16'd1)
                    bus.m_last = 1'b1;
                if (word_done) begin
                    count_next = 16'd0;
                    if (state == CHECKSUM && plen_q == 16'd0)
                        state_next = IDLE;
                    else
                        state_next = header_next(state);
                end else if (bus.m_ready) begin
                    count_next = 16'd1;
                end
            end

            PAYLOAD: begin
                bus.m_data  = bus.s_data;
                bus.m_valid = bus.s_valid;
                bus.s_ready = bus.m_ready;
                bus.m_last  = bus.s_valid && (count == plen_q - 16'd1);
                if (bus.s_valid && bus.m_ready) begin
                    if (count == plen_q - 16'd1) begin
                        count_next = 16'd0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + 16'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                count_next = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_udp_header_tx.sv
// Directed bench for udp_header_tx: table of datagrams checked byte by byte, plus
// hand-written length-reject and mid-datagram reset sequences.
module tb_udp_header_tx;
    import eth_pkg::*;

    logic aclk;
    logic areset;

    udp_header_tx_if u_if ();

    udp_header_tx #(.MAX_PAYLOAD(1472)) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (u_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] ps;
        logic [15:0] pd;
        logic [15:0] len;
        logic [15:0] lenf;   // hand-computed UDP length field
        logic [15:0] cs;
        int          mode;   // 0: always ready, 1: m_ready toggles, 2: random ready + source gaps
        bit          inject; // pulse start during payload, must be ignored
    } dg_t;

    dg_t         tbl[7];
    logic [7:0]  exp_q[$];
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        u_if.start       = 1'b0;
        u_if.port_s      = 16'h0000;
        u_if.port_d      = 16'h0000;
        u_if.payload_len = 16'h0000;
`ifdef UDP_CHECKSUM_EN
        u_if.checksum    = 16'h0000;
`endif
        u_if.s_data      = 8'h00;
        u_if.s_valid     = 1'b0;
        u_if.m_ready     = 1'b0;
    endtask

    task automatic run_dgram(input dg_t d, input string name);
        int         total;
        int         idx;
        int         pidx;
        int         cyc;
        int         budget;
        bit         have_hold;
        bit         injected;
        logic [7:0] hold_data;
        logic [15:0] cs_exp;

`ifdef UDP_CHECKSUM_EN
        cs_exp = d.cs;
`else
        cs_exp = 16'h0000;
`endif
        exp_q.delete();
        exp_q.push_back(d.ps[15:8]);   exp_q.push_back(d.ps[7:0]);
        exp_q.push_back(d.pd[15:8]);   exp_q.push_back(d.pd[7:0]);
        exp_q.push_back(d.lenf[15:8]); exp_q.push_back(d.lenf[7:0]);
        exp_q.push_back(cs_exp[15:8]); exp_q.push_back(cs_exp[7:0]);
        for (int i = 0; i < int'(d.len); i++) exp_q.push_back(8'hD0 + 8'(i));
        total  = exp_q.size();
        budget = total * 8 + 50;

        @(negedge aclk);
        u_if.start       = 1'b1;
        u_if.port_s      = d.ps;
        u_if.port_d      = d.pd;
        u_if.payload_len = d.len;
`ifdef UDP_CHECKSUM_EN
        u_if.checksum    = d.cs;
`endif
        u_if.s_valid     = 1'b0;
        u_if.m_ready     = 1'b1;
        #1;
        check({name, "_busy_before"}, 32'(u_if.busy), 32'd0);
        check({name, "_mvalid_before"}, 32'(u_if.m_valid), 32'd0);
        @(posedge aclk);

        idx = 0; pidx = 0; cyc = 0; have_hold = 0; injected = 0; hold_data = 8'h00;
        while (idx < total && cyc < budget) begin
            @(negedge aclk);
            cyc++;
            u_if.start       = 1'b0;
            u_if.port_s      = 16'hDEAD;
            u_if.port_d      = 16'hBEEF;
            u_if.payload_len = 16'd5;
            if (d.inject && !injected && idx >= 8) begin
                u_if.start = 1'b1;
                injected   = 1;
            end
            case (d.mode)
                0: u_if.m_ready = 1'b1;
                1: u_if.m_ready = (cyc % 2) == 1;
                default: u_if.m_ready = 1'($urandom_range(0, 1));
            endcase
            u_if.s_valid = have_hold ? 1'b1 : ((d.mode == 2) ? ((cyc % 3) != 0) : 1'b1);
            u_if.s_data  = 8'hD0 + 8'(pidx);
            #1;
            if (idx < 8) check({name, "_sready_hdr"}, 32'(u_if.s_ready), 32'd0);
            if (have_hold) begin
                check({name, "_stall_valid"}, 32'(u_if.m_valid), 32'd1);
                check({name, "_stall_data"}, 32'(u_if.m_data), 32'(hold_data));
            end
            have_hold = 0;
            if (u_if.m_valid) begin
                check($sformatf("%s_byte%0d", name, idx), 32'(u_if.m_data), 32'(exp_q[idx]));
                check($sformatf("%s_last%0d", name, idx), 32'(u_if.m_last), 32'(idx == total - 1));
                if (u_if.m_ready) begin
                    if (idx >= 8) pidx++;
                    idx++;
                end else begin
                    have_hold = 1;
                    hold_data = u_if.m_data;
                end
            end
            @(posedge aclk);
        end
        if (idx < total) check({name, "_timeout"}, 32'(idx), 32'(total));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();

        //            ps        pd        len     lenf      cs        mode inject
        tbl[0] = '{16'h1234, 16'hABCD, 16'd4,    16'h000C, 16'h0000, 0, 0};
        tbl[1] = '{16'h0050, 16'h1F90, 16'd0,    16'h0008, 16'h0000, 0, 0};
        tbl[2] = '{16'h1234, 16'hABCD, 16'd4,    16'h000C, 16'h0000, 1, 0};
        tbl[3] = '{16'hFFFF, 16'h0001, 16'd3,    16'h000B, 16'h0000, 2, 1};
        tbl[4] = '{16'h0400, 16'h0800, 16'd1472, 16'h05C8, 16'h0000, 0, 0};
        tbl[5] = '{16'h00FF, 16'hFF00, 16'd1,    16'h0009, 16'h0000, 1, 1};
        tbl[6] = '{16'h1111, 16'h2222, 16'd2,    16'h000A, 16'hBEEF, 0, 1};

        areset = 1'b1;
        #12;
        check("rst_mvalid", 32'(u_if.m_valid), 32'd0);
        check("rst_mdata",  32'(u_if.m_data),  32'd0);
        check("rst_mlast",  32'(u_if.m_last),  32'd0);
        check("rst_sready", 32'(u_if.s_ready), 32'd0);
        check("rst_busy",   32'(u_if.busy),    32'd0);
        check("rst_lenerr", 32'(u_if.len_err), 32'd0);
        @(negedge aclk);
        areset = 1'b0;

        // Consecutive table entries are back to back: each start lands in the cycle IDLE returns.
        for (int t = 0; t < 7; t++) run_dgram(tbl[t], $sformatf("dg%0d", t));

        @(negedge aclk);
        #1;
        check("end_busy", 32'(u_if.busy), 32'd0);

        // Oversized request is rejected with a single-cycle pulse.
        @(negedge aclk);
        u_if.start       = 1'b1;
        u_if.port_s      = 16'h1234;
        u_if.port_d      = 16'h5678;
        u_if.payload_len = 16'd1473;
        u_if.m_ready     = 1'b1;
        #1;
        check("lenerr_pulse",  32'(u_if.len_err), 32'd1);
        check("lenerr_mvalid", 32'(u_if.m_valid), 32'd0);
        @(negedge aclk);
        u_if.start = 1'b0;
        #1;
        check("lenerr_drop", 32'(u_if.len_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lenerr_busy%0d", i),   32'(u_if.busy),    32'd0);
            check($sformatf("lenerr_mvalid%0d", i), 32'(u_if.m_valid), 32'd0);
            @(negedge aclk);
            #1;
        end

        // Reset while the destination port is being sent aborts the datagram.
        @(negedge aclk);
        u_if.start       = 1'b1;
        u_if.port_s      = 16'h1234;
        u_if.port_d      = 16'hABCD;
        u_if.payload_len = 16'd4;
        u_if.m_ready     = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        u_if.start = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        #1;
        check("abort_pre_data", 32'(u_if.m_data), 32'hAB);
        areset = 1'b1;
        #1;
        check("abort_mvalid", 32'(u_if.m_valid), 32'd0);
        check("abort_mdata",  32'(u_if.m_data),  32'd0);
        check("abort_busy",   32'(u_if.busy),    32'd0);
        check("abort_mlast",  32'(u_if.m_last),  32'd0);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        run_dgram(tbl[0], "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
